// File: rtl/count_check_pkg.sv
// Shared types and constants for the count checker.
// State encoding, output-select codes, uio bit positions, uio_oe value.
package count_check_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [1:0] SEL_LAST = 2'b00;
  localparam logic [1:0] SEL_EXP  = 2'b01;
  localparam logic [1:0] SEL_ERR  = 2'b10;
  localparam logic [1:0] SEL_RUN  = 2'b11;

  localparam int UIO_STB    = 0;
  localparam int UIO_RSY    = 1;
  localparam int UIO_CLR    = 2;
  localparam int UIO_SEL    = 3;
  localparam int UIO_LOCK   = 5;
  localparam int UIO_STICKY = 6;
  localparam int UIO_PULSE  = 7;

  localparam logic [7:0] UIO_OE_VAL = 8'b1110_0000;

endpackage

// File: rtl/sat_inc8.sv
// 8-bit saturating incrementer with clear; clear applies before increment.
// Ports: val (current), clr, inc -> nxt (next value).
module sat_inc8 (
  input  logic [7:0] val,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] nxt
);

  logic [7:0] base;

  // clr together with inc yields 1 (restart a count)
  always_comb begin
    base = clr ? 8'd0 : val;
    nxt  = base;
    if (inc && base != 8'hFF)
      nxt = base + 8'd1;
  end

endmodule

// File: rtl/tt_um_count_checker.sv
// Sequence checker: samples ui_in on a strobe edge, tracks +1 steps.
// Ports: clk, rst_n, ena, ui_in, uio_in -> uo_out, uio_out, uio_oe.
// Optional input synchronizer: define COUNT_CHECK_SYNC_EN.
module tt_um_count_checker
  import count_check_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       stb;
  logic       rsy;
  logic       clr;
  logic [7:0] din;

`ifdef COUNT_CHECK_SYNC_EN
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [7:0] din_q;

  // data is delayed one cycle to stay aligned with the synced strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      din_q   <= '0;
    end else begin
      sync1_q <= uio_in[2:0];
      sync2_q <= sync1_q;
      din_q   <= ui_in;
    end
  end

  assign stb = sync2_q[UIO_STB];
  assign rsy = sync2_q[UIO_RSY];
  assign clr = sync2_q[UIO_CLR];
  assign din = din_q;
`else
  assign stb = uio_in[UIO_STB];
  assign rsy = uio_in[UIO_RSY];
  assign clr = uio_in[UIO_CLR];
  assign din = ui_in;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in[7:5]};

  state_t     state_q;
  state_t     state_d;
  logic [7:0] last_q;
  logic [7:0] exp_q;
  logic [7:0] run_q;
  logic [7:0] err_q;
  logic [7:0] run_d;
  logic [7:0] err_d;
  logic       sticky_q;
  logic       pulse_q;
  logic       stb_q;
  logic       locked;

  logic take;
  logic match;
  logic err_ev;
  logic run_clr;
  logic run_inc;

  // edge history runs regardless of ena, so an edge seen while
  // disabled is consumed and lost
  assign take   = stb & ~stb_q & ena & ~rsy;
  assign match  = (din == exp_q);
  assign err_ev = take & (state_q != ST_UNLOCKED) & ~match;

  // run restarts at 1 when (re)locking, goes to 0 on a mismatch
  assign run_clr = rsy
                 | (take & ~((state_q == ST_LOCKED) & match));
  assign run_inc = take
                 & ((state_q == ST_UNLOCKED) | match);

  sat_inc8 u_run (
    .val (run_q),
    .clr (run_clr),
    .inc (run_inc),
    .nxt (run_d)
  );

  sat_inc8 u_err (
    .val (err_q),
    .clr (clr),
    .inc (err_ev & ~clr),
    .nxt (err_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_UNLOCKED;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rsy) begin
      state_d = ST_UNLOCKED;
    end else if (take) begin
      unique case (state_q)
        ST_UNLOCKED: state_d = ST_LOCKED;
        ST_LOCKED:   state_d = match ? ST_LOCKED : ST_ERROR;
        ST_ERROR:    state_d = match ? ST_LOCKED : ST_ERROR;
        default:     state_d = ST_UNLOCKED;
      endcase
    end
  end

  always_comb begin
    locked = (state_q == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= '0;
      exp_q    <= '0;
      run_q    <= '0;
      err_q    <= '0;
      sticky_q <= 1'b0;
      pulse_q  <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      stb_q   <= stb;
      pulse_q <= take;
      run_q   <= run_d;
      err_q   <= err_d;
      if (take) begin
        last_q <= din;
        exp_q  <= din + 8'd1;
      end
      if (clr)
        sticky_q <= 1'b0;
      else if (err_ev)
        sticky_q <= 1'b1;
    end
  end

  always_comb begin
    unique case (uio_in[UIO_SEL+1:UIO_SEL])
      SEL_LAST: uo_out = last_q;
      SEL_EXP:  uo_out = exp_q;
      SEL_ERR:  uo_out = err_q;
      SEL_RUN:  uo_out = run_q;
      default:  uo_out = last_q;
    endcase
  end

  assign uio_out = {pulse_q, sticky_q, locked, 5'b0};
  assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_count_checker.sv
// Self-checking bench for tt_um_count_checker.
// Directed scenarios plus randomized traffic against a reference model.
module tb_tt_um_count_checker;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic       stb   = 1'b0;
  logic       rsy   = 1'b0;
  logic       clr   = 1'b0;
  logic [1:0] sel   = 2'd0;
  logic [2:0] junk  = 3'd0;
  logic [7:0] seq   = 8'd0;

  wire [7:0] uio_in = {junk, sel, clr, rsy, stb};
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_bad = 0;

  tt_um_count_checker dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  typedef enum {M_FREE, M_TRACK, M_BAD} mode_t;
  mode_t m_mode;
  int    m_last, m_exp, m_run, m_err;
  bit    m_sticky, m_pulse, m_prev, m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_FREE;
      m_last = 0; m_exp = 0; m_run = 0; m_err = 0;
      m_sticky = 0; m_pulse = 0; m_prev = 0;
    end else begin
      m_acc   = stb && !m_prev && ena;
      m_prev  = stb;
      m_pulse = m_acc && !rsy;
      if (rsy) begin
        m_mode = M_FREE;
        m_run  = 0;
      end else if (m_acc) begin
        if (m_mode == M_FREE) begin
          m_run  = 1;
          m_mode = M_TRACK;
        end else if (int'(ui_in) == m_exp) begin
          if (m_mode == M_BAD) m_run = 1;
          else m_run = (m_run < 255) ? m_run + 1 : 255;
          m_mode = M_TRACK;
        end else begin
          m_run    = 0;
          m_err    = (m_err < 255) ? m_err + 1 : 255;
          m_sticky = 1;
          m_mode   = M_BAD;
        end
        m_last = int'(ui_in);
        m_exp  = (int'(ui_in) + 1) % 256;
      end
      if (clr) begin
        m_err    = 0;
        m_sticky = 0;
      end
    end
  end

  function automatic logic [7:0] want_uo();
    case (sel)
      2'd0:    return 8'(m_last);
      2'd1:    return 8'(m_exp);
      2'd2:    return 8'(m_err);
      default: return 8'(m_run);
    endcase
  endfunction

  task automatic check(input string name,
                       input logic [7:0] got,
                       input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h t=%0t",
               name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("uo_out", uo_out, want_uo());
      check("uio_out", uio_out,
            {m_pulse, m_sticky, m_mode == M_TRACK, 5'b0});
      check("uio_oe", uio_oe, 8'hE0);
    end
  end

  task automatic sample(input logic [7:0] d);
    @(posedge clk); #1;
    ui_in = d;
    stb   = 1'b1;
    @(posedge clk); #1;
    stb   = 1'b0;
  endtask

  task automatic resync();
    @(posedge clk); #1;
    rsy = 1'b1;
    @(posedge clk); #1;
    rsy = 1'b0;
  endtask

  task automatic peek(input logic [1:0] s, input string name,
                      input logic [7:0] want);
    sel = s;
    #1;
    check(name, uo_out, want);
  endtask

  initial begin
    #2;
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hE0);
    #20;
    rst_n = 1'b1;

    sample(8'd5); sample(8'd6); sample(8'd7);
    check("t1_flags", uio_out, 8'hA0);
    peek(2'd3, "t1_run", 8'd3);
    peek(2'd2, "t1_err", 8'd0);
    peek(2'd1, "t1_exp", 8'd8);

    resync();
    sample(8'hFE); sample(8'hFF); sample(8'h00);
    check("t2_flags", uio_out, 8'hA0);
    peek(2'd3, "t2_run", 8'd3);
    peek(2'd2, "t2_err", 8'd0);

    resync();
    sample(8'd10);
    sample(8'd12);
    check("t3_flags12", uio_out, 8'hC0);
    peek(2'd3, "t3_run12", 8'd0);
    peek(2'd2, "t3_err12", 8'd1);
    sample(8'd13);
    check("t3_flags13", uio_out, 8'hE0);
    peek(2'd3, "t3_run13", 8'd1);

    @(posedge clk); #1;
    ui_in = 8'd50; stb = 1'b1; rsy = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; rsy = 1'b0;
    check("t4_rsy_flags", uio_out, 8'h40);
    peek(2'd0, "t4_rsy_last", 8'd13);
    peek(2'd3, "t4_rsy_run", 8'd0);

    sample(8'd20);
    @(posedge clk); #1;
    ui_in = 8'd99; stb = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; clr = 1'b0;
    check("t4_clr_flags", uio_out, 8'h80);
    peek(2'd2, "t4_clr_err", 8'd0);
    sample(8'd100);
    check("t4_relock", uio_out, 8'hA0);
    peek(2'd3, "t4_relock_run", 8'd1);

    repeat (300) sample(8'd0);
    check("t5_flags", uio_out, 8'hC0);
    peek(2'd2, "t5_err_sat", 8'hFF);
    peek(2'd3, "t5_run", 8'd0);

    ena = 1'b0;
    sample(8'd1);
    check("t5_ena_flags", uio_out, 8'h40);
    peek(2'd0, "t5_ena_last", 8'd0);
    peek(2'd3, "t5_ena_run", 8'd0);
    ena = 1'b1;

    resync();
    sample(8'd40); sample(8'd41);
    sel = 2'd1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t6_uo", uo_out, 8'h00);
    check("t6_uio", uio_out, 8'h00);
    @(negedge clk); #2;
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) begin
        stb = ~stb;
        if (stb) begin
          seq   = ($urandom_range(0, 9) < 7) ? seq + 8'd1
                                             : 8'($urandom);
          ui_in = seq;
        end
      end
      rsy  = ($urandom_range(0, 24) == 0);
      clr  = ($urandom_range(0, 39) == 0);
      ena  = ($urandom_range(0, 9) != 0);
      sel  = 2'($urandom);
      junk = 3'($urandom);
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_um_count_checker.md
# tt_um_count_checker

Receive-side companion to the loadable 8-bit up-counter. It samples an 8-bit count bus on a strobe, locks onto the sequence, checks that each new sample equals the previous one plus 1 (modulo 256), and counts mismatches and good-run length. Results go out on the dedicated outputs through a selectable mux. It sits on the far end of the counter's `uo_out` bus as a self-check and bring-up monitor.

## Interface
- No parameters; all widths are fixed at 8 bits.
- `clk`  in  1  Single clock.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `ena`  in  1  Enable. Strobes are accepted only while high.
- `ui_in`  in  8  Sampled count value.
- `uio_in`  in  8
  - [0] sample strobe
  - [1] resync request (level)
  - [2] clear errors (level)
  - [4:3] output select
  - [7:5] ignored
- `uo_out`  out  8  Selected result: 00 last sample, 01 expected next, 10 error count, 11 run length.
- `uio_out`  out  8
  - [7] sample_pulse
  - [6] err_sticky
  - [5] locked
  - [4:0] 0
- `uio_oe`  out  8  Constant 8'b1110_0000.

## Operation
- **Sample acceptance:** a sample is accepted on the clock edge where strobe=1 and the registered strobe was 0, with ena=1.
  - The strobe history register updates every cycle, regardless of ena.
  - A strobe edge that occurs while ena=0 is lost.
- **States:** UNLOCKED, LOCKED, ERROR.
  - **UNLOCKED, on sample:** last←data; expected←data+1; run←1; go to LOCKED.
  - **LOCKED, match (data==expected):** last←data; expected←data+1; run←run+1.
  - **LOCKED, mismatch:** last←data; expected←data+1 (re-anchor); run←0; err_cnt←err_cnt+1; err_sticky←1; go to ERROR.
  - **ERROR, match:** run←1; go to LOCKED.
  - **ERROR, mismatch:** same updates as the LOCKED mismatch; stay in ERROR.
  - **Resync (level high):** go to UNLOCKED; clear run. Last, expected, err_cnt and err_sticky are kept.
- **Arithmetic:**
  - expected wraps 8'hFF→8'h00, so 255 followed by 0 is a match.
  - run and err_cnt saturate at 8'hFF and never wrap.
- **Priority:**
  - Resync beats a simultaneous sample; the sample is discarded.
  - Clear beats an error increment in the same cycle: err_cnt=0 and err_sticky=0. The state transition still occurs.
- **Outputs:**
  - locked = (state==LOCKED).
  - sample_pulse is high for exactly one cycle after each accepted sample.
- **Reset:** all registers are 0 and state is UNLOCKED. Consequently uo_out=0 and uio_out=0.
- **Mid-operation reset:** reset asserted at any time returns every register to these values immediately, without waiting for a clock.

## Timing
- The strobe edge is seen at clock N. All registers update at edge N, so results are visible on uo_out and uio_out right after edge N: 1-cycle latency from strobe high.
- uo_out is a combinational mux of registers. A select change is visible in the same cycle.
- The minimum strobe period is 2 cycles (high 1, low 1).
- With `COUNT_CHECK_SYNC_EN`, add 2 cycles of latency on uio_in[2:0].

## Configuration
- **`COUNT_CHECK_SYNC_EN` defined:**
  - A two-flop synchronizer is placed on strobe, resync and clear before edge detection.
  - ui_in is captured one cycle after the strobe for data alignment.
  - Latency becomes 3 cycles.
- **`COUNT_CHECK_SYNC_EN` undefined:** inputs are treated as synchronous to clk, and the latency is as stated under Timing.

## Structure
- **Package `count_check_pkg`:**
  - state enum (UNLOCKED / LOCKED / ERROR)
  - output-select codes
  - uio bit-index constants
  - the `UIO_OE_VAL` constant
- **Sub-module `sat_inc8`:** 8-bit increment with saturation, with a clear input. It is instantiated for run and err_cnt.

## Test plan
1. **Reset and lock:** reset, then strobe samples 5, 6, 7 → locked=1, run=3, err_cnt=0; sel=01 gives uo_out=8.
2. **Wrap-around:** samples 8'hFE, 8'hFF, 8'h00 → no errors, run=3, locked=1.
3. **Mismatch and recovery:** locked at 10, then samples 12, 13 → err_cnt=1, err_sticky=1, run after 12 = 0, run after 13 = 1, locked=1 after 13.
4. **Priorities:**
   - resync with a simultaneous strobe of 50 → state UNLOCKED, last is unchanged.
   - clear in the same cycle as a mismatch → err_cnt=0, state ERROR.
5. **Saturation and ena gating:**
   - 300 consecutive mismatches → err_cnt=255.
   - strobe while ena=0 → no register change and no sample_pulse.
6. **Async reset:** assert rst_n low between clock edges while locked → all outputs 0 with no clock edge.
